// File: rtl/uart_pkg.sv
// Shared UART constants: default oversample ratio, fractional width and minimum divisor.
// Pure declarations, no logic; imported by the baud generator and its interface.
package uart_pkg;

    localparam int UART_OSR_DEF = 16;
    localparam int UART_FW_DEF  = 4;
    localparam int UART_MIN_DIV = 2;

    // Bits needed to hold an oversample index 0..osr-1.
    function automatic int os_cnt_w(input int osr);
        return (osr > 1) ? $clog2(osr) : 1;
    endfunction

endpackage

// File: rtl/uart_baud_frac_if.sv
// CSR-to-baud-generator bundle: per-channel divisor config/strobes in, per-channel ticks and error out.
// Flat vectors, channel k occupying slice k of each field.
interface uart_baud_frac_if #(
    parameter int NCH = 2,
    parameter int IW  = 16,
    parameter int FW  = 4
) ();

    logic [NCH*IW-1:0] cfg_div_int;
    logic [NCH*FW-1:0] cfg_div_frac;
    logic [NCH-1:0]    cfg_load;
    logic [NCH-1:0]    ch_en;
    logic [NCH-1:0]    phase_rst;
    logic [NCH-1:0]    os_tick;
    logic [NCH-1:0]    bit_tick;
    logic [NCH-1:0]    mid_tick;
    logic [NCH-1:0]    cfg_err;

    modport master (
        output cfg_div_int, cfg_div_frac, cfg_load, ch_en, phase_rst,
        input  os_tick, bit_tick, mid_tick, cfg_err
    );

    modport slave (
        input  cfg_div_int, cfg_div_frac, cfg_load, ch_en, phase_rst,
        output os_tick, bit_tick, mid_tick, cfg_err
    );

endinterface

// File: rtl/uart_baud_ch.sv
// One fractional baud channel: os/mid/bit ticks every div_int + div_frac/2^FW clocks, registered.
// First os_tick P clocks after phase_rst or start; no backpressure, ticks are single-cycle strobes.
module uart_baud_ch
    import uart_pkg::*;
#(
    parameter int IW  = 16,
    parameter int FW  = UART_FW_DEF,
    parameter int OSR = UART_OSR_DEF
) (
    input  logic          clk_sys,
    input  logic          rst_n,
    input  logic [IW-1:0] div_int,
    input  logic [FW-1:0] div_frac,
    input  logic          load,
    input  logic          en,
    input  logic          phase_rst,
    output logic          os_tick,
    output logic          bit_tick,
    output logic          mid_tick,
    output logic          cfg_err
);

    localparam int             OSW     = os_cnt_w(OSR);
    localparam logic [OSW-1:0] OS_LAST = OSW'(OSR - 1);
    localparam logic [OSW-1:0] OS_MID  = OSW'(OSR / 2 - 1);
    localparam logic [IW-1:0]  MIN_DIV = IW'(UART_MIN_DIV);
    localparam logic [IW:0]    ONE_W   = (IW+1)'(1);

    logic [IW-1:0]  sh_int;
    logic [FW-1:0]  sh_frac;
    logic [IW-1:0]  pend_int;
    logic [FW-1:0]  pend_frac;
    logic           pend_vld;

    logic [IW-1:0]  cnt;
    logic [FW-1:0]  acc;
    logic [OSW-1:0] os_cnt;

    logic           run;
    logic [FW:0]    sum;
    logic [IW:0]    period;
    logic           last;
    logic           boundary;
    logic           apply_now;

    // Period is one wider than div_int so the carry cannot wrap a full-scale divisor.
    always_comb begin
        run       = en && (sh_int >= MIN_DIV);
        sum       = {1'b0, acc} + {1'b0, sh_frac};
        period    = {1'b0, sh_int} + {{IW{1'b0}}, sum[FW]};
        last      = run && ({1'b0, cnt} == (period - ONE_W));
        boundary  = last && !phase_rst;
        apply_now = load && (!run || phase_rst);
    end

    // Divisor shadow: immediate when idle or re-phasing, otherwise deferred to the next os boundary.
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            sh_int    <= '0;
            sh_frac   <= '0;
            pend_int  <= '0;
            pend_frac <= '0;
            pend_vld  <= 1'b0;
        end else if (apply_now || (boundary && load)) begin
            sh_int    <= div_int;
            sh_frac   <= div_frac;
            pend_vld  <= 1'b0;
        end else if (boundary && pend_vld) begin
            sh_int    <= pend_int;
            sh_frac   <= pend_frac;
            pend_vld  <= 1'b0;
        end else if (load) begin
            pend_int  <= div_int;
            pend_frac <= div_frac;
            pend_vld  <= 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_n || phase_rst || !run) begin
            cnt    <= '0;
            acc    <= '0;
            os_cnt <= '0;
        end else if (last) begin
            cnt    <= '0;
            acc    <= sum[FW-1:0];
            os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + OSW'(1);
        end else begin
            cnt    <= cnt + IW'(1);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            os_tick  <= 1'b0;
            bit_tick <= 1'b0;
            mid_tick <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            os_tick  <= boundary;
            bit_tick <= boundary && (os_cnt == OS_LAST);
            mid_tick <= boundary && (os_cnt == OS_MID);
            cfg_err  <= en && (sh_int < MIN_DIV);
        end
    end

endmodule

// File: rtl/uart_baud_frac.sv
// NCH independent fractional baud channels behind one config/tick bundle.
// Latency and tick timing are those of uart_baud_ch; no backpressure.
module uart_baud_frac
    import uart_pkg::*;
#(
    parameter int NCH = 2,
    parameter int IW  = 16,
    parameter int FW  = UART_FW_DEF,
    parameter int OSR = UART_OSR_DEF
) (
    input  logic              clk_sys,
    input  logic              rst_n,
    uart_baud_frac_if.slave   bus
);

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        uart_baud_ch #(
            .IW  (IW),
            .FW  (FW),
            .OSR (OSR)
        ) u_ch (
            .clk_sys   (clk_sys),
            .rst_n     (rst_n),
            .div_int   (bus.cfg_div_int[k*IW +: IW]),
            .div_frac  (bus.cfg_div_frac[k*FW +: FW]),
            .load      (bus.cfg_load[k]),
            .en        (bus.ch_en[k]),
            .phase_rst (bus.phase_rst[k]),
            .os_tick   (bus.os_tick[k]),
            .bit_tick  (bus.bit_tick[k]),
            .mid_tick  (bus.mid_tick[k]),
            .cfg_err   (bus.cfg_err[k])
        );
    end

endmodule

// File: tb/tb_uart_baud_frac.sv
// Directed bench for uart_baud_frac: a tick model fills per-channel queues of expected tick cycles,
// and every cycle's observed ticks are popped and compared.
module tb_uart_baud_frac;

    localparam int NCH = 2;
    localparam int IW  = 16;
    localparam int FW  = 4;
    localparam int OSR = 16;
    localparam int BIG = 1 << 30;

    logic clk_sys = 1'b0;
    logic rst_n;

    always #5 clk_sys = ~clk_sys;

    uart_baud_frac_if #(.NCH(NCH), .IW(IW), .FW(FW)) bus ();

    uart_baud_frac #(.NCH(NCH), .IW(IW), .FW(FW), .OSR(OSR)) dut (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    int cyc;
    int checks;
    int errors;
    int exp_q [NCH][3][$];   // kind 0 = os, 1 = mid, 2 = bit
    int last_bit [NCH];
    int bit_per  [NCH];
    int t0, a0, o0, t1, a1, o1;
    int tm, s6, r6;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic string kname(input int k);
        return (k == 0) ? "os_tick" : (k == 1) ? "mid_tick" : "bit_tick";
    endfunction

    task automatic check_ticks();
        logic [NCH-1:0] v [3];
        int e;
        v[0] = bus.os_tick;
        v[1] = bus.mid_tick;
        v[2] = bus.bit_tick;
        for (int ch = 0; ch < NCH; ch++) begin
            for (int k = 0; k < 3; k++) begin
                if (v[k][ch]) begin
                    e = (exp_q[ch][k].size() > 0) ? exp_q[ch][k].pop_front() : -1;
                    chk($sformatf("%s ch%0d cycle", kname(k), ch), cyc, e);
                    if (k == 2) begin
                        if (last_bit[ch] >= 0) bit_per[ch] = cyc - last_bit[ch];
                        last_bit[ch] = cyc;
                    end
                end else if (exp_q[ch][k].size() > 0 && exp_q[ch][k][0] <= cyc) begin
                    e = exp_q[ch][k].pop_front();
                    chk($sformatf("%s ch%0d missing at cycle %0d", kname(k), ch, e),
                        {31'd0, v[k][ch]}, 1);
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        cyc++;
        @(negedge clk_sys);
        check_ticks();
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic set_div(input int ch, input int di, input int df);
        bus.cfg_div_int[ch*IW +: IW]  = IW'(di);
        bus.cfg_div_frac[ch*FW +: FW] = FW'(df);
    endtask

    // Reference tick model: t = last tick cycle, acc = fractional accumulator, osc = os index.
    task automatic push_ticks(input int ch, inout int t, inout int acc, inout int osc,
                              input int div, input int frac, input int n, input int limit);
        int sum;
        int p;
        for (int i = 0; i < n; i++) begin
            sum = acc + frac;
            p   = div + ((sum >= (1 << FW)) ? 1 : 0);
            if (t + p > limit) break;
            t   = t + p;
            acc = sum % (1 << FW);
            exp_q[ch][0].push_back(t);
            if (osc == OSR/2 - 1) exp_q[ch][1].push_back(t);
            if (osc == OSR - 1)   exp_q[ch][2].push_back(t);
            osc = (osc == OSR - 1) ? 0 : osc + 1;
        end
    endtask

    initial begin
        cyc = 0; checks = 0; errors = 0;
        for (int ch = 0; ch < NCH; ch++) begin
            last_bit[ch] = -1;
            bit_per[ch]  = 0;
        end
        bus.cfg_div_int  = '0;
        bus.cfg_div_frac = '0;
        bus.cfg_load     = '0;
        bus.ch_en        = '0;
        bus.phase_rst    = '0;
        rst_n            = 1'b0;
        repeat (3) tick();
        chk("reset os_tick",  {30'd0, bus.os_tick},  0);
        chk("reset bit_tick", {30'd0, bus.bit_tick}, 0);
        chk("reset mid_tick", {30'd0, bus.mid_tick}, 0);
        chk("reset cfg_err",  {30'd0, bus.cfg_err},  0);
        rst_n = 1'b1;
        tick();

        // Integer divisor 10 started by phase_rst: os every 10, mid at +80, bit every 160.
        set_div(0, 10, 0);
        bus.cfg_load[0] = 1'b1;
        tick();
        bus.cfg_load[0]  = 1'b0;
        bus.ch_en[0]     = 1'b1;
        bus.phase_rst[0] = 1'b1;
        tick();
        bus.phase_rst[0] = 1'b0;
        t0 = cyc; a0 = 0; o0 = 0;
        push_ticks(0, t0, a0, o0, 10, 0, 32, BIG);
        wait_until(t0);
        chk("div10 bit period", bit_per[0], 160);

        // Re-phase 4 clocks after a tick: old slot stays silent, counting restarts.
        tm = t0;
        wait_until(tm + 3);
        bus.phase_rst[0] = 1'b1;
        tick();
        bus.phase_rst[0] = 1'b0;
        t0 = cyc; a0 = 0; o0 = 0;
        chk("phase_rst edge no tick", {31'd0, bus.os_tick[0]}, 0);
        push_ticks(0, t0, a0, o0, 10, 0, 16, BIG);
        wait_until(tm + 10);
        chk("old slot suppressed", {31'd0, bus.os_tick[0]}, 0);
        wait_until(t0);

        // Load 20 while running: current period completes at 10, then 20.
        tm = t0;
        wait_until(tm + 2);
        set_div(0, 20, 0);
        bus.cfg_load[0] = 1'b1;
        tick();
        bus.cfg_load[0] = 1'b0;
        push_ticks(0, t0, a0, o0, 10, 0, 1, BIG);
        push_ticks(0, t0, a0, o0, 20, 0, 16, BIG);
        wait_until(t0);

        // Fractional 10 + 8/16 with load+phase_rst together: bit period exactly 168.
        tm = t0;
        wait_until(tm + 4);
        set_div(0, 10, 8);
        bus.cfg_load[0]  = 1'b1;
        bus.phase_rst[0] = 1'b1;
        tick();
        bus.cfg_load[0]  = 1'b0;
        bus.phase_rst[0] = 1'b0;
        t0 = cyc; a0 = 0; o0 = 0;
        push_ticks(0, t0, a0, o0, 10, 8, 32, BIG);
        wait_until(t0);
        chk("frac bit period", bit_per[0], 168);
        bus.ch_en[0] = 1'b0;
        tick();

        // Invalid divisor 1 on ch1: no ticks, cfg_err; then divisor 4 clears it.
        bus.ch_en[1] = 1'b1;
        set_div(1, 1, 0);
        bus.cfg_load[1] = 1'b1;
        tick();
        bus.cfg_load[1] = 1'b0;
        tick();
        chk("div1 cfg_err set", {31'd0, bus.cfg_err[1]}, 1);
        repeat (10) tick();
        chk("div1 cfg_err held", {31'd0, bus.cfg_err[1]}, 1);
        chk("ch0 cfg_err idle", {31'd0, bus.cfg_err[0]}, 0);
        set_div(1, 4, 0);
        bus.cfg_load[1] = 1'b1;
        tick();
        bus.cfg_load[1] = 1'b0;
        t1 = cyc; a1 = 0; o1 = 0;
        chk("div4 cfg_err latency", {31'd0, bus.cfg_err[1]}, 1);
        tick();
        chk("div4 cfg_err clear", {31'd0, bus.cfg_err[1]}, 0);
        push_ticks(1, t1, a1, o1, 4, 0, 20, BIG);
        wait_until(t1);

        // Two channels at 7 and 12, then a one-cycle reset mid-bit.
        set_div(0, 7, 0);
        set_div(1, 12, 0);
        bus.ch_en     = '1;
        bus.cfg_load  = '1;
        bus.phase_rst = '1;
        tick();
        bus.cfg_load  = '0;
        bus.phase_rst = '0;
        s6 = cyc;
        r6 = s6 + 100;
        t0 = s6; a0 = 0; o0 = 0;
        t1 = s6; a1 = 0; o1 = 0;
        push_ticks(0, t0, a0, o0, 7,  0, 64, r6 - 1);
        push_ticks(1, t1, a1, o1, 12, 0, 64, r6 - 1);
        wait_until(r6 - 1);
        rst_n = 1'b0;
        tick();
        chk("mid-run reset os_tick",  {30'd0, bus.os_tick},  0);
        chk("mid-run reset bit_tick", {30'd0, bus.bit_tick}, 0);
        chk("mid-run reset mid_tick", {30'd0, bus.mid_tick}, 0);
        chk("mid-run reset cfg_err",  {30'd0, bus.cfg_err},  0);
        rst_n = 1'b1;
        tick();
        chk("shadow cleared cfg_err", {30'd0, bus.cfg_err}, 3);
        repeat (30) tick();
        bus.ch_en = '0;
        repeat (2) tick();
        chk("disabled cfg_err", {30'd0, bus.cfg_err}, 0);

        for (int ch = 0; ch < NCH; ch++)
            for (int k = 0; k < 3; k++)
                chk($sformatf("%s ch%0d left in queue", kname(k), ch), exp_q[ch][k].size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
